// File: rtl/condition_unit_pkg.sv
// Shared definitions for the execute-stage condition logic.
// Contents:
//   OPC_COND        opcode of the conditional instruction class
//   cond_e          condition select encoding for the conditional class
//   FLAG_N..FLAG_V  bit positions of N, Z, C, V inside a {N,Z,C,V} flag vector
package condition_unit_pkg;

  localparam logic [2:0] OPC_COND = 3'b011;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    NE = 2'b01,
    GE = 2'b10,
    LT = 2'b11
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/condition_unit_if.sv
// Execute-stage control bundle seen by the condition unit.
// Signals:
//   PCSrcE, RegWriteE, MemWriteE, BranchE  execute-stage control requests
//   FlagWriteE[1:0]   flag-write enables ([1] = N,Z ; [0] = C,V)
//   Opcode[2:0]       instruction class
//   S[1:0]            condition select for the conditional class
//   FlagsE[3:0]       flags tested by this instruction {N,Z,C,V}
//   ALUFlags[3:0]     new flags produced by the ALU {N,Z,C,V}
//   ALUFlagsD[3:0]    stored flag register, returned to decode
//   BranchTakenE      branch taken
//   PCSrcM, RegWriteM, MemWriteM  gated controls toward the memory stage
// Modports: master drives the requests (pipeline side), slave is the unit.
interface condition_unit_if;

  logic       PCSrcE;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       BranchE;
  logic [1:0] FlagWriteE;
  logic [2:0] Opcode;
  logic [1:0] S;
  logic [3:0] FlagsE;
  logic [3:0] ALUFlags;

  logic [3:0] ALUFlagsD;
  logic       BranchTakenE;
  logic       PCSrcM;
  logic       RegWriteM;
  logic       MemWriteM;

  modport master (
    output PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE,
           Opcode, S, FlagsE, ALUFlags,
    input  ALUFlagsD, BranchTakenE, PCSrcM, RegWriteM, MemWriteM
  );

  modport slave (
    input  PCSrcE, RegWriteE, MemWriteE, BranchE, FlagWriteE,
           Opcode, S, FlagsE, ALUFlags,
    output ALUFlagsD, BranchTakenE, PCSrcM, RegWriteM, MemWriteM
  );

endinterface

// File: rtl/condition_unit_check.sv
// condition_check: decides whether the current instruction executes.
// Ports:
//   i_opcode[2:0]  instruction class; only OPC_COND is conditional
//   i_s[1:0]       condition select (cond_e)
//   i_flags[3:0]   flags seen by this instruction {N,Z,C,V}
//   o_cond_ex      1 = instruction executes
// Purely combinational.
module condition_check
  import condition_unit_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_s,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // o_cond_ex unassigned, which would infer a latch.
    o_cond_ex = 1'b1;
    if (i_opcode == OPC_COND) begin
      case (cond_e'(i_s))
        EQ:      o_cond_ex =  i_flags[FLAG_Z];
        NE:      o_cond_ex = ~i_flags[FLAG_Z];
        GE:      o_cond_ex = (i_flags[FLAG_N] == i_flags[FLAG_V]);
        LT:      o_cond_ex = (i_flags[FLAG_N] != i_flags[FLAG_V]);
        default: o_cond_ex = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/condition_unit.sv
// condition_unit: execute-stage condition logic of the SIMD/AES pipeline.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low clear of the flag register
//   bus   condition_unit_if.slave (control requests in, gated controls
//         and stored flags out)
// The gated controls are combinational and do not depend on rst; only the
// NZCV flag register is clocked.
module condition_unit
  import condition_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  condition_unit_if.slave       bus
);

  logic       w_cond_ex;
  logic [3:0] r_flags;

  condition_check u_condition_check (
    .i_opcode  (bus.Opcode),
    .i_s       (bus.S),
    .i_flags   (bus.FlagsE),
    .o_cond_ex (w_cond_ex)
  );

  assign bus.PCSrcM       = bus.PCSrcE    & w_cond_ex;
  assign bus.RegWriteM    = bus.RegWriteE & w_cond_ex;
  assign bus.MemWriteM    = bus.MemWriteE & w_cond_ex;
  // Conditional-class instructions are branches in their own right.
  assign bus.BranchTakenE = (bus.BranchE | (bus.Opcode == OPC_COND)) & w_cond_ex;

  // Two independently enabled halves: {N,Z} and {C,V}. The async clear wins
  // over any write presented in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every
      // register samples the pre-edge values regardless of statement order.
      if (bus.FlagWriteE[1] & w_cond_ex)
        r_flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (bus.FlagWriteE[0] & w_cond_ex)
        r_flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign bus.ALUFlagsD = r_flags;

endmodule

// File: tb/tb_condition_unit.sv
// Directed bench for condition_unit. Each step drives one set of inputs
// just after a rising edge and queues the hand-computed outputs expected
// for that cycle; a monitor samples on the falling edge and compares.
module tb_condition_unit;

  logic clk;
  logic rst;

  condition_unit_if bus ();

  condition_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       pcm;
    logic       rwm;
    logic       mwm;
    logic       bt;
    logic [3:0] fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation is queued per stimulus cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " PCSrcM"},       {3'b0, bus.PCSrcM},       {3'b0, e.pcm});
      check({e.name, " RegWriteM"},    {3'b0, bus.RegWriteM},    {3'b0, e.rwm});
      check({e.name, " MemWriteM"},    {3'b0, bus.MemWriteM},    {3'b0, e.mwm});
      check({e.name, " BranchTakenE"}, {3'b0, bus.BranchTakenE}, {3'b0, e.bt});
      check({e.name, " ALUFlagsD"},    bus.ALUFlagsD,            e.fd);
    end
  end

  task automatic step(
    input string name, input logic rst_v,
    input logic pc, input logic rw, input logic mw, input logic br,
    input logic [1:0] fw, input logic [2:0] opc, input logic [1:0] s,
    input logic [3:0] fe, input logic [3:0] alu,
    input logic epc, input logic erw, input logic emw, input logic ebt,
    input logic [3:0] efd
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst            = rst_v;
    bus.PCSrcE     = pc;
    bus.RegWriteE  = rw;
    bus.MemWriteE  = mw;
    bus.BranchE    = br;
    bus.FlagWriteE = fw;
    bus.Opcode     = opc;
    bus.S          = s;
    bus.FlagsE     = fe;
    bus.ALUFlags   = alu;
    e.name = name; e.pcm = epc; e.rwm = erw; e.mwm = emw; e.bt = ebt; e.fd = efd;
    exp_q.push_back(e);
  endtask

  initial begin
    rst            = 1'b0;
    bus.PCSrcE     = 1'b0;
    bus.RegWriteE  = 1'b0;
    bus.MemWriteE  = 1'b0;
    bus.BranchE    = 1'b0;
    bus.FlagWriteE = 2'b00;
    bus.Opcode     = 3'b000;
    bus.S          = 2'b00;
    bus.FlagsE     = 4'b0000;
    bus.ALUFlags   = 4'b0000;

    //   name        rst pc rw mw br fw     opc     s      flagsE   aluflags  | pcm rwm mwm bt flagsD
    step("reset",    0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 4'b0000, 4'b1111,  0, 0, 0, 0, 4'b0000);
    step("uncond_a", 1, 1, 1, 0, 0, 2'b00, 3'b110, 2'b11, 4'b0000, 4'b0000,  1, 1, 0, 0, 4'b0000);
    step("uncond_b", 1, 1, 1, 0, 0, 2'b00, 3'b110, 2'b11, 4'b0100, 4'b0000,  1, 1, 0, 0, 4'b0000);
    step("eq_pass",  1, 1, 1, 1, 0, 2'b00, 3'b011, 2'b00, 4'b0100, 4'b0000,  1, 1, 1, 1, 4'b0000);
    step("eq_fail",  1, 1, 1, 1, 0, 2'b00, 3'b011, 2'b00, 4'b0000, 4'b0000,  0, 0, 0, 0, 4'b0000);
    step("ne_pass",  1, 1, 1, 1, 0, 2'b00, 3'b011, 2'b01, 4'b0000, 4'b0000,  1, 1, 1, 1, 4'b0000);
    step("ne_fail",  1, 1, 1, 1, 0, 2'b00, 3'b011, 2'b01, 4'b0100, 4'b0000,  0, 0, 0, 0, 4'b0000);
    step("ge_pass",  1, 1, 0, 0, 0, 2'b00, 3'b011, 2'b10, 4'b1001, 4'b0000,  1, 0, 0, 1, 4'b0000);
    step("lt_fail",  1, 1, 1, 1, 1, 2'b00, 3'b011, 2'b11, 4'b1001, 4'b0000,  0, 0, 0, 0, 4'b0000);
    step("lt_pass",  1, 0, 1, 0, 0, 2'b00, 3'b011, 2'b11, 4'b1000, 4'b0000,  0, 1, 0, 1, 4'b0000);
    step("br_uncond",1, 0, 0, 1, 1, 2'b00, 3'b000, 2'b00, 4'b0110, 4'b0000,  0, 0, 1, 1, 4'b0000);
    // Flag register: upper half, then lower half, then observe.
    step("fw_nz",    1, 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 4'b0000, 4'b1111,  0, 0, 0, 0, 4'b0000);
    step("fw_cv",    1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 4'b0000, 4'b1111,  0, 0, 0, 0, 4'b1100);
    step("fw_hold",  1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 4'b0000, 4'b0000,  0, 0, 0, 0, 4'b1111);
    // Failed condition suppresses a full flag write.
    step("fw_supp",  1, 0, 0, 0, 0, 2'b11, 3'b011, 2'b00, 4'b0000, 4'b0000,  0, 0, 0, 0, 4'b1111);
    step("supp_obs", 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 4'b0000, 4'b0000,  0, 0, 0, 0, 4'b1111);
    step("fw_all",   1, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 4'b0000, 4'b0101,  0, 0, 0, 0, 4'b1111);
    // GE tests FlagsE (N==V) even though the stored flags would say N!=V.
    step("ge_flagsE",1, 0, 0, 0, 0, 2'b00, 3'b011, 2'b10, 4'b0000, 4'b0000,  0, 0, 0, 1, 4'b0101);
    // Write lands at the next edge, then reset is asserted mid-cycle.
    step("pre_rst",  1, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 4'b0000, 4'b1010,  0, 0, 0, 0, 4'b0101);
    step("mid_rst",  0, 1, 0, 0, 0, 2'b11, 3'b000, 2'b00, 4'b0000, 4'b1111,  1, 0, 0, 0, 4'b0000);
    step("rst_hold", 0, 0, 1, 1, 1, 2'b11, 3'b000, 2'b00, 4'b0000, 4'b1111,  0, 1, 1, 1, 4'b0000);
    step("rst_rel",  1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 4'b0000, 4'b0000,  0, 0, 0, 0, 4'b0000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
